// File: rtl/inst_rom_loader.sv
// Instruction ROM with a zero-latency fetch port and a byte-serial boot loader.
// Define INST_ROM_CHECKSUM_EN to require a 4-byte sum trailer after the program.
`timescale 1ns/1ps
module inst_rom_loader #(
   parameter int ADDR_W = 10,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rom_ce_i,
   input  logic [31:0]       rom_addr_i,
   output logic [WORD_W-1:0] rom_data_o,
   input  logic              ld_start_i,
   input  logic [ADDR_W:0]   ld_len_i,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_byte_i,
   output logic              ld_ready_o,
   output logic              ld_busy_o,
   output logic              boot_done_o,
   output logic              ld_err_o
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

`ifdef INST_ROM_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE, S_ERR} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

   state_t            r_state;
   logic [1:0]        r_byte_cnt;
   logic [ADDR_W:0]   r_word_ptr;
   logic [ADDR_W:0]   r_len;
   logic [WORD_W-1:0] r_word;
   logic              r_ready;
   logic              r_busy;
   logic              r_done;
   logic [WORD_W-1:0] r_mem [DEPTH];
`ifdef INST_ROM_CHECKSUM_EN
   logic [WORD_W-1:0] r_sum;
   logic              r_err;
`endif

   logic [ADDR_W:0]   w_len_clamped;
   logic [ADDR_W:0]   w_ptr_next;
   logic [WORD_W-1:0] w_word_next;
   logic              w_byte_take;
   logic              w_start;
   logic              w_unused;

   assign w_len_clamped = (ld_len_i > DEPTH_L) ? DEPTH_L : ld_len_i;
   assign w_ptr_next    = r_word_ptr + ONE_L;
   assign w_word_next   = {r_word[WORD_W-9:0], ld_byte_i};
   assign w_byte_take   = ld_valid_i & r_ready;
   // Busy is high exactly in the receive states, so a start pulse is only honoured outside them.
   assign w_start       = ld_start_i & ~r_busy;
   assign w_unused      = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-low.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_byte_cnt <= '0;
         r_word_ptr <= '0;
         r_len      <= '0;
         r_word     <= '0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef INST_ROM_CHECKSUM_EN
         r_sum      <= '0;
         r_err      <= 1'b0;
`endif
      end else if (w_start) begin
         r_len      <= w_len_clamped;
         r_word_ptr <= '0;
         r_byte_cnt <= '0;
         r_done     <= 1'b0;
`ifdef INST_ROM_CHECKSUM_EN
         r_sum      <= '0;
         r_err      <= 1'b0;
         r_ready    <= 1'b1;
         r_busy     <= 1'b1;
         r_state    <= (w_len_clamped == '0) ? S_CHECK : S_RECV;
`else
         if (w_len_clamped == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
         end else begin
            r_state <= S_RECV;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
         end
`endif
      end else begin
         case (r_state)
            S_RECV: begin
               if (w_byte_take) begin
                  r_word     <= w_word_next;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     r_state <= S_WRITE;
                     r_ready <= 1'b0;
                  end
               end
            end
            S_WRITE: begin
               r_word_ptr <= w_ptr_next;
               r_byte_cnt <= '0;
`ifdef INST_ROM_CHECKSUM_EN
               r_sum      <= r_sum + r_word;
`endif
               if (w_ptr_next == r_len) begin
`ifdef INST_ROM_CHECKSUM_EN
                  r_state <= S_CHECK;
                  r_ready <= 1'b1;
`else
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
`endif
               end else begin
                  r_state <= S_RECV;
                  r_ready <= 1'b1;
               end
            end
`ifdef INST_ROM_CHECKSUM_EN
            S_CHECK: begin
               if (w_byte_take) begin
                  r_word     <= w_word_next;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     r_ready <= 1'b0;
                     r_busy  <= 1'b0;
                     if (w_word_next == r_sum) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                     end
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // NOTE: the memory array is deliberately not reset so it maps onto block RAM and survives a reset.
   always_ff @(posedge clk) begin
      if (rst && r_state == S_WRITE)
         r_mem[r_word_ptr[ADDR_W-1:0]] <= r_word;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rom_data_o = '0;
      if (rst && rom_ce_i && !r_busy)
         rom_data_o = r_mem[rom_addr_i[ADDR_W+1:2]];
   end

   assign ld_ready_o  = r_ready;
   assign ld_busy_o   = r_busy;
   assign boot_done_o = r_done;
`ifdef INST_ROM_CHECKSUM_EN
   assign ld_err_o    = r_err;
`else
   assign ld_err_o    = 1'b0;
`endif

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
Instruction-memory responder for the core's fetch port. It serves rom_ce/rom_addr requests with same-cycle instruction data, which the IF/ID register captures. It also holds a byte-serial boot-loader FSM that fills the memory from a host stream before the core runs. The top level holds the core in reset until boot_done_o is asserted.

Parameters:
ADDR_W, 10, word-address width; memory depth DEPTH = 2^ADDR_W 32-bit words
WORD_W, 32, instruction width; fixed at 32, big-endian byte assembly

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
rom_ce_i  input  1  fetch enable from the core's PC register
rom_addr_i  input  32  fetch byte address; bits [ADDR_W+1:2] select the word
rom_data_o  output  32  instruction returned to the core
ld_start_i  input  1  one-cycle pulse that begins a load
ld_len_i  input  ADDR_W+1  number of words to load, latched at start
ld_valid_i  input  1  host byte valid
ld_byte_i  input  8  host byte
ld_ready_o  output  1  loader accepts a byte this cycle
ld_busy_o  output  1  load in progress
boot_done_o  output  1  program loaded; core may be released
ld_err_o  output  1  checksum mismatch (see Optional Feature)

Behaviour:
- Clock is clk only. rst is synchronous and active-low: all state updates on the rising edge of clk while rst==0.
- Reset values: FSM=IDLE; byte_cnt=0; word_ptr=0; len=0; ld_ready_o=0; ld_busy_o=0; boot_done_o=0; ld_err_o=0. rom_data_o=0 while rst==0. Memory contents are not cleared.
- FSM states: IDLE, RECV, WRITE, CHECK (only with the feature), DONE, ERR (only with the feature).
- IDLE:
  - ld_start_i=1 latches len = min(ld_len_i, DEPTH).
  - len==0: go to DONE. Otherwise go to RECV with word_ptr=0 and byte_cnt=0.
- RECV:
  - ld_ready_o=1, ld_busy_o=1.
  - A byte is accepted when ld_valid_i & ld_ready_o. The first byte fills word bits [31:24], the last fills [7:0].
  - After the 4th accepted byte, go to WRITE.
- WRITE (one cycle):
  - ld_ready_o=0, so any byte presented this cycle is not consumed.
  - mem[word_ptr] <= assembled word; word_ptr++; byte_cnt=0.
  - If word_ptr+1==len, go to DONE (CHECK with the feature). Otherwise return to RECV.
  - Minimum cost is 5 cycles per word.
- DONE:
  - boot_done_o=1, ld_busy_o=0, ld_ready_o=0.
  - ld_start_i restarts the load as in IDLE; boot_done_o drops on the next cycle.
- ld_start_i is ignored in RECV, WRITE and CHECK.
- Fetch path (combinational, 0 latency):
  - rom_data_o = mem[rom_addr_i[ADDR_W+1:2]] when rst==1, rom_ce_i==1 and ld_busy_o==0. Otherwise rom_data_o=0 (a NOP).
  - rom_addr_i[1:0] and bits above ADDR_W+1 are ignored, so addresses alias modulo DEPTH words.
- Reset mid-load: the FSM returns to IDLE and words already written stay in memory. A fresh ld_start_i reloads from word 0.

Optional Feature:
INST_ROM_CHECKSUM_EN
- Enabled:
  - A 32-bit running sum (mod 2^32) accumulates every written word; it clears at ld_start_i.
  - After the last WRITE, the FSM enters CHECK and receives 4 trailer bytes (big-endian) with the same handshake as RECV.
  - Trailer == sum: go to DONE.
  - Trailer != sum: go to ERR, with ld_err_o=1, boot_done_o=0, ld_busy_o=0. ERR leaves only on ld_start_i, which clears ld_err_o.
  - len==0 goes straight to CHECK; the expected trailer is 0.
- Disabled: no CHECK/ERR states, no trailer bytes, ld_err_o tied to 0.

Test Plan:
1. Hold rst=0 for 2 cycles with rom_ce_i=1 -> rom_data_o=0, ld_ready_o=0, ld_busy_o=0, boot_done_o=0, ld_err_o=0.
2. ld_len_i=2, bytes 3C 01 12 34 34 21 00 05 sent back-to-back -> mem[0]=0x3C011234, mem[1]=0x34210005. boot_done_o=1 the cycle after the 2nd WRITE. Then rom_addr_i=0x00000004, rom_ce_i=1 -> rom_data_o=0x34210005; rom_ce_i=0 -> 0; rom_addr_i=0x00001004 -> 0x34210005 (alias).
3. ld_valid_i held high through a WRITE cycle, plus random valid gaps -> the byte presented in WRITE is not consumed and is taken the next cycle; stored words match step 2.
4. ld_len_i=0 -> boot_done_o=1 one cycle after the start pulse. rom_data_o is 0 throughout any load while ld_busy_o=1.
5. rst=0 after 6 bytes of a 2-word load -> FSM is IDLE and boot_done_o=0. Reloading words 0xAABBCCDD,0x11223344 -> mem[0]=0xAABBCCDD.
6. INST_ROM_CHECKSUM_EN, step-2 words:
   - Trailer 70 22 12 39 -> boot_done_o=1, ld_err_o=0.
   - Trailer 70 22 12 38 -> ld_err_o=1, boot_done_o=0; the next ld_start_i clears ld_err_o.
